// File: rtl/counter_compare_pkg.sv
// Shared definitions for counter_compare: FSM state encoding, event codes, width default.
package counter_compare_pkg;

  localparam int unsigned CC_WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } cc_state_e;

  localparam logic [1:0] EVT_NONE  = 2'b00;
  localparam logic [1:0] EVT_MATCH = 2'b01;
  localparam logic [1:0] EVT_WRAP  = 2'b10;
  localparam logic [1:0] EVT_BOTH  = 2'b11;

  function automatic logic [1:0] evt_encode(input logic m, input logic w);
    return {w, m};
  endfunction

endpackage

// File: rtl/counter_compare_evt_fifo.sv
// compare_evt_fifo: synchronous event queue of 2-bit codes; a push on a full
// queue is accepted when a pop happens in the same cycle, otherwise reported as a drop.
module compare_evt_fifo
  import counter_compare_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [1:0] push_data,
  input  logic       pop,
  output logic       valid,
  output logic [1:0] head,
  output logic       drop
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [1:0]  mem_q [DEPTH];
  logic [1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          full, empty, push_ok, pop_ok;

  always_comb begin
    empty   = (count_q == '0);
    full    = (count_q == (AW+1)'(DEPTH));
    pop_ok  = pop && !empty;
    push_ok = push && (!full || pop_ok);
    drop    = push && full && !pop_ok;

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    count_d = count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);

    valid = !empty;
    head  = empty ? EVT_NONE : mem_q[rd_ptr_q];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/counter_compare.sv
// Compare/PWM unit watching an external loadable counter; queues match/wrap events.
// Optional PWM output enabled by defining COUNTER_COMPARE_PWM_EN.
module counter_compare
  import counter_compare_pkg::*;
#(
  parameter int unsigned WIDTH     = CC_WIDTH_DEFAULT,
  parameter int unsigned EVT_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] cnt,
  input  logic             cnt_en,
  input  logic             cnt_load,
  input  logic             cmp_wr,
  input  logic [WIDTH-1:0] cmp_data,
  input  logic             arm,
  input  logic             stop,
  input  logic             oneshot,
  input  logic             evt_ready,
  input  logic             ovf_clr,
  output logic             pwm,
  output logic             match,
  output logic             wrap,
  output logic             evt_valid,
  output logic [1:0]       evt_code,
  output logic             evt_ovf,
  output logic [1:0]       state
);

  cc_state_e        state_q, state_d;
  logic [WIDTH-1:0] cnt_d_q, cnt_d_d;
  logic             en_d_q, en_d_d;
  logic             load_d_q, load_d_d;
  logic [WIDTH-1:0] cmp_shadow_q, cmp_shadow_d;
  logic [WIDTH-1:0] cmp_active_q, cmp_active_d;
  logic             match_q, match_d;
  logic             wrap_q, wrap_d;
  logic             pwm_q, pwm_d;
  logic             ovf_q, ovf_d;
  logic             wrap_det, match_det, in_run;
  logic             fifo_drop;

  always_comb begin
    cnt_d_d  = cnt;
    en_d_d   = cnt_en;
    load_d_d = cnt_load;

    in_run    = (state_q == ST_RUN);
    wrap_det  = (cnt_d_q == '1) && (cnt == '0) && en_d_q && !load_d_q;
    // A held counter re-matches only when it was just reloaded.
    match_det = (cnt == cmp_active_q) && ((cnt != cnt_d_q) || load_d_q);
    match_d   = in_run && match_det;
    wrap_d    = in_run && wrap_det;

    cmp_shadow_d = cmp_wr ? cmp_data : cmp_shadow_q;
    // Active compare takes the pre-write shadow, so a same-cycle write waits a lap.
    cmp_active_d = cmp_active_q;
    if ((state_q == ST_IDLE) || (in_run && wrap_det)) cmp_active_d = cmp_shadow_q;

`ifdef COUNTER_COMPARE_PWM_EN
    pwm_d = in_run && (cnt < cmp_active_q);
`else
    pwm_d = 1'b0;
`endif

    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (arm) state_d = ST_RUN;
      ST_RUN: begin
        if (stop)                       state_d = ST_IDLE;
        else if (match_det && oneshot)  state_d = ST_DONE;
      end
      ST_DONE: begin
        if (stop)     state_d = ST_IDLE;
        else if (arm) state_d = ST_RUN;
      end
      default: state_d = ST_IDLE;
    endcase

    ovf_d = fifo_drop ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_d_q      <= '0;
      en_d_q       <= 1'b0;
      load_d_q     <= 1'b0;
      cmp_shadow_q <= '1;
      cmp_active_q <= '1;
      match_q      <= 1'b0;
      wrap_q       <= 1'b0;
      pwm_q        <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_d_q      <= cnt_d_d;
      en_d_q       <= en_d_d;
      load_d_q     <= load_d_d;
      cmp_shadow_q <= cmp_shadow_d;
      cmp_active_q <= cmp_active_d;
      match_q      <= match_d;
      wrap_q       <= wrap_d;
      pwm_q        <= pwm_d;
      ovf_q        <= ovf_d;
    end
  end

  compare_evt_fifo #(
    .DEPTH(EVT_DEPTH)
  ) u_evt_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (match_q | wrap_q),
    .push_data(evt_encode(match_q, wrap_q)),
    .pop      (evt_ready),
    .valid    (evt_valid),
    .head     (evt_code),
    .drop     (fifo_drop)
  );

  assign pwm     = pwm_q;
  assign match   = match_q;
  assign wrap    = wrap_q;
  assign evt_ovf = ovf_q;
  assign state   = state_q;

endmodule
